// File: rtl/attobus_if.sv
// Bundle of requester, memory and status signals for the two-requester attobus arbiter.
// The arbiter connects to it through the slave modport; the master modport is the environment's view.
interface attobus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              lock0;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        output gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        input  gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/attobus_arbiter.sv
// Two-requester arbiter for a single-port memory: IDLE -> ACCESS -> CAPTURE -> ACK per transaction.
// Define ATTOBUS_RR_EN for round-robin tie resolution; otherwise requester 0 wins ties.
module attobus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic      clock,
    input  logic      reset,
    attobus_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t            state_r;
    logic              win_r;
    logic              lock_r;
    logic              gnt0_r;
    logic              gnt1_r;
    logic              ack0_r;
    logic              ack1_r;
    logic              busy_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] rdata_r;

    logic              win_s;
    logic              tie_s;
    logic              sel_we_s;
    logic              sel_lock_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

`ifdef ATTOBUS_RR_EN
    assign tie_s = ~win_r;
`else
    assign tie_s = 1'b0;
`endif

    // Winner selection: a held lock beats the tie rule, a lone requester wins outright.
    always_comb begin
        win_s = 1'b0;
        if (lock_r && ((!win_r && bus.req0) || (win_r && bus.req1))) begin
            win_s = win_r;
        end else if (bus.req0 && bus.req1) begin
            win_s = tie_s;
        end else if (bus.req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Request field mux for the selected winner.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (win_s) begin
            sel_we_s    = bus.we1;
            sel_lock_s  = bus.lock1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_we_s    = bus.we0;
            sel_lock_s  = bus.lock0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Transaction FSM with all outputs registered; win_r doubles as lock owner and RR pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            win_r       <= 1'b1;
            lock_r      <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            busy_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rdata_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state_r     <= ACCESS;
                        win_r       <= win_s;
                        lock_r      <= sel_lock_s;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        mem_en_r    <= 1'b1;
                        gnt0_r      <= ~win_s;
                        gnt1_r      <= win_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    mem_en_r <= 1'b0;
                    state_r  <= CAPTURE;
                end
                CAPTURE: begin
                    if (!mem_we_r) begin
                        rdata_r <= bus.mem_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    ack0_r  <= ~win_r;
                    ack1_r  <= win_r;
                    state_r <= ACK;
                end
                ACK: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    gnt0_r   <= 1'b0;
                    gnt1_r   <= 1'b0;
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.busy      = busy_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rdata     = rdata_r;
endmodule

// File: tb/tb_attobus_arbiter.sv
// Bench for attobus_arbiter: directed vector table, randomized transactions against a
// transaction-level reference model, and hand sequences for tie, lock and mid-op reset.
module tb_attobus_arbiter;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    attobus_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    attobus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        req0;
        logic        we0;
        logic        lock0;
        logic [15:0] addr0;
        logic [7:0]  wdata0;
        logic        req1;
        logic        we1;
        logic        lock1;
        logic [15:0] addr1;
        logic [7:0]  wdata1;
        int          exp_w;
        logic [7:0]  exp_rd;
    } vec_t;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i) ^ 8'h5A;
        if (i == 8'h34) v = 8'hA5;
        return v;
    endfunction

    // Memory: one-cycle read latency, write on the strobe; refilled with a fixed pattern on reset.
    logic [7:0] mem_arr [256];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else bus.mem_rdata <= mem_arr[bus.mem_addr[7:0]];
        end
    end

    // Reference model: who owns the bus last, whether they hold a lock, memory contents, last read.
    int         m_last;
    bit         m_lock;
    logic [7:0] m_rd;
    logic [7:0] shadow [256];

    task automatic m_reset();
        m_last = 1;
        m_lock = 1'b0;
        m_rd   = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    endtask

    function automatic int m_pick(input vec_t v);
        if (!v.req0 && !v.req1) return -1;
        if (m_lock && ((m_last == 0 && v.req0) || (m_last == 1 && v.req1))) return m_last;
        if (v.req0 && v.req1) begin
`ifdef ATTOBUS_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        return v.req1 ? 1 : 0;
    endfunction

    task automatic m_commit(input vec_t v, input int w);
        logic        we;
        logic [15:0] a;
        if (w < 0) return;
        m_last = w;
        m_lock = (w == 1) ? v.lock1 : v.lock0;
        we     = (w == 1) ? v.we1 : v.we0;
        a      = (w == 1) ? v.addr1 : v.addr0;
        if (we) shadow[a[7:0]] = (w == 1) ? v.wdata1 : v.wdata0;
        else m_rd = shadow[a[7:0]];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 16'h0000; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 16'h0000; bus.wdata1 = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        drive_idle();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_reset();
    endtask

    function automatic vec_t mk(input bit r0, input bit w0, input bit l0, input logic [15:0] a0,
                                input logic [7:0] d0, input bit r1, input bit w1, input bit l1,
                                input logic [15:0] a1, input logic [7:0] d1, input int ew,
                                input logic [7:0] er);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.lock0 = l0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.we1 = w1; v.lock1 = l1; v.addr1 = a1; v.wdata1 = d1;
        v.exp_w = ew; v.exp_rd = er;
        return v;
    endfunction

    // One transaction from the IDLE cycle N: checks strobe at N+1, quiet N+2, ack and rdata at N+3.
    task automatic run_txn(input vec_t v, input int ew, input logic [7:0] er);
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        @(negedge clock);
        bus.req0 = v.req0; bus.we0 = v.we0; bus.lock0 = v.lock0; bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
        bus.req1 = v.req1; bus.we1 = v.we1; bus.lock1 = v.lock1; bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
        @(negedge clock);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (ew < 0) begin
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_mem_en", bus.mem_en, 1'b0);
            chk("idle_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
            chk("idle_rdata", bus.rdata, er);
            return;
        end
        we = (ew == 1) ? v.we1 : v.we0;
        a  = (ew == 1) ? v.addr1 : v.addr0;
        d  = (ew == 1) ? v.wdata1 : v.wdata0;
        chk("gnt", {bus.gnt1, bus.gnt0}, (ew == 1) ? 2'b10 : 2'b01);
        chk("mem_en", bus.mem_en, 1'b1);
        chk("mem_we", bus.mem_we, we);
        chk("mem_addr", bus.mem_addr, a);
        if (we) chk("mem_wdata", bus.mem_wdata, d);
        chk("busy", bus.busy, 1'b1);
        @(negedge clock);
        chk("capture_mem_en", bus.mem_en, 1'b0);
        chk("capture_ack", {bus.ack1, bus.ack0}, 2'b00);
        @(negedge clock);
        chk("ack", {bus.ack1, bus.ack0}, (ew == 1) ? 2'b10 : 2'b01);
        chk("ack_gnt", {bus.gnt1, bus.gnt0}, (ew == 1) ? 2'b10 : 2'b01);
        chk("rdata", bus.rdata, er);
    endtask

    vec_t tbl [8];

    initial begin
        vec_t v;
        int   w;
        int   exp_seq [4];
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive_idle();

        tbl[0] = mk(1, 0, 0, 16'h1234, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 8'hA5);
        tbl[1] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h00FF, 8'h3C, 1, 8'hA5);
        tbl[2] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h00FF, 8'h00, 1, 8'h3C);
        tbl[3] = mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 16'h0010, 8'h77, 1, 8'h3C);
        tbl[4] = mk(1, 0, 0, 16'h0010, 8'h00, 1, 0, 0, 16'h00FF, 8'h00, 1, 8'h3C);
        tbl[5] = mk(1, 0, 0, 16'h0010, 8'h00, 1, 0, 0, 16'h00FF, 8'h00, 0, 8'h77);
`ifdef ATTOBUS_RR_EN
        tbl[6] = mk(1, 0, 0, 16'h2034, 8'h00, 1, 0, 0, 16'h00FF, 8'h00, 1, 8'h3C);
        tbl[7] = mk(0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, -1, 8'h3C);
`else
        tbl[6] = mk(1, 0, 0, 16'h2034, 8'h00, 1, 0, 0, 16'h00FF, 8'h00, 0, 8'hA5);
        tbl[7] = mk(0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, -1, 8'hA5);
`endif

        do_reset();
        @(negedge clock);
        chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
        chk("rst_mem", {bus.mem_en, bus.mem_we, bus.busy}, 3'b000);
        chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 24'h000000);
        chk("rst_rdata", bus.rdata, 8'h00);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], tbl[i].exp_w, tbl[i].exp_rd);
            m_commit(tbl[i], tbl[i].exp_w);
        end

        for (int i = 0; i < 60; i++) begin
            v.req0   = ($urandom_range(0, 2) != 0);
            v.we0    = 1'($urandom_range(0, 1));
            v.lock0  = ($urandom_range(0, 2) == 0);
            v.addr0  = 16'($urandom);
            v.wdata0 = 8'($urandom);
            v.req1   = ($urandom_range(0, 2) != 0);
            v.we1    = 1'($urandom_range(0, 1));
            v.lock1  = ($urandom_range(0, 2) == 0);
            v.addr1  = 16'($urandom);
            v.wdata1 = 8'($urandom);
            w = m_pick(v);
            m_commit(v, w);
            run_txn(v, w, m_rd);
        end

        // Continuous tie: grants every 4 cycles, alternating only with round-robin.
        do_reset();
        @(negedge clock);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
`ifdef ATTOBUS_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("tie_gnt", {bus.gnt1, bus.gnt0}, (exp_seq[k] == 1) ? 2'b10 : 2'b01);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            chk("tie_idle_gap", bus.busy, 1'b0);
        end
        drive_idle();

        // Lock: lock0 latched on the first grant keeps requester 0 for the second one.
        do_reset();
        @(negedge clock);
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clock);
        chk("lock_gnt_1", {bus.gnt1, bus.gnt0}, 2'b01);
        bus.lock0 = 1'b0;
        repeat (4) @(negedge clock);
        chk("lock_gnt_2", {bus.gnt1, bus.gnt0}, 2'b01);
        repeat (4) @(negedge clock);
`ifdef ATTOBUS_RR_EN
        chk("lock_gnt_3", {bus.gnt1, bus.gnt0}, 2'b10);
`else
        chk("lock_gnt_3", {bus.gnt1, bus.gnt0}, 2'b01);
`endif
        drive_idle();

        // Reset during ACCESS abandons the transaction and restores requester 0's tie priority.
        do_reset();
        @(negedge clock);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clock);
        chk("mid_access_mem_en", bus.mem_en, 1'b1);
        reset = 1'b0;
        drive_idle();
        @(negedge clock);
        chk("mid_rst_mem_en", bus.mem_en, 1'b0);
        chk("mid_rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ack", {bus.ack1, bus.ack0}, 2'b00);
        reset = 1'b1;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_no_ack", {bus.ack1, bus.ack0}, 2'b00);
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clock);
        chk("post_rst_tie", {bus.gnt1, bus.gnt0}, 2'b01);
        drive_idle();
        repeat (4) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Bus-wide invariants sampled every cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.gnt0 && bus.gnt1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dual_gnt: got gnt0=1 gnt1=1 expected at most one");
            end
            if (bus.ack0 && bus.ack1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dual_ack: got ack0=1 ack1=1 expected at most one");
            end
        end
    end
endmodule
